alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between NREQ requesters (sequencer, address unit, debug port) with a round-robin policy. It drives the ALU operand, op and enable inputs and returns each result and condition bit to the requester that issued it. A lock mechanism gives one requester exclusive access for multi-byte chains (ADD then ADDC..., SUB then SWB...), so the ALU's internal carry buffer is never disturbed by another requester mid-chain.

Parameters:
NREQ, 2, number of requesters (2..4)
LOCK_TIMEOUT, 16, idle cycles a locked owner may hold the ALU without a valid request before the lock is force-released (>=1)

Ports:
clk  in  1  system clock
async_rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept; transfer when valid&&ready
req_a  in  8*NREQ  operand A, requester i at [8i+7:8i]
req_b  in  8*NREQ  operand B, same packing
req_op  in  4*NREQ  ALU op code, requester i at [4i+3:4i]
req_lock  in  NREQ  keep grant after this op (chain continues)
rsp_valid  out  NREQ  result held for requester i
rsp_ready  in  NREQ  requester consumes result
rsp_data  out  8*NREQ  captured ALU out per requester
rsp_cond  out  NREQ  captured ALU condition per requester
alu_a  out  8  to ALU a
alu_b  out  8  to ALU b
alu_op  out  4  to ALU op
alu_clk_en  out  1  to ALU clk_en; high only in the issue cycle
alu_sync_rst  out  1  to ALU sync_rst
alu_out  in  8  from ALU out
alu_cond  in  1  from ALU condition
lock_owner  out  2  current lock owner index (debug)
locked  out  1  lock held (debug)

Behaviour:
- Reset (async_rst_n=0): rsp_valid=0, rsp_data=0, rsp_cond=0, locked=0, lock_owner=0, rr pointer=NREQ-1, timeout counter=0, init flag=1. req_ready=0 and alu_clk_en=0 while in reset.
- alu_sync_rst = init flag; the flag clears on the first clk edge after reset release. Exactly one cycle of alu_sync_rst clears the ALU carry buffer. No grants are given in that cycle.
- Eligible(i) = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
- Grant, combinational:
  - If locked, only lock_owner may be granted.
  - Otherwise the first eligible index after the rr pointer, searched cyclically.
  - At most one grant per cycle. req_ready[i] = grant[i].
- Issue cycle (transfer on i):
  - alu_a/b/op = requester i fields; alu_clk_en=1.
  - On the same edge: rsp_data[i]<=alu_out, rsp_cond[i]<=alu_cond, rsp_valid[i]<=1.
  - Latency: result visible 1 cycle after transfer. Throughput: 1 op/cycle.
- Idle cycles: alu_a/b=0, alu_op=0, alu_clk_en=0. The carry buffer is held.
- rsp_valid[i] clears on rsp_ready[i] unless a new transfer for i occurs on the same edge. In that case the new result is loaded and valid stays 1.
- rr pointer <= i on every transfer.
- Lock FSM:
  - UNLOCKED -> LOCKED(owner=i) on a transfer with req_lock[i]=1.
  - LOCKED -> UNLOCKED on an owner transfer with req_lock=0; that op is the final op of the chain.
  - LOCKED with an owner transfer and req_lock=1 stays LOCKED and clears the timeout counter.
  - While LOCKED and the owner issues no transfer, the counter increments. When it reaches LOCK_TIMEOUT-1, the next edge forces UNLOCKED and clears the counter.
  - Other requesters stall (req_ready=0) while LOCKED.
- An owner that is valid but blocked by its own full rsp register still counts toward the timeout.
- Async reset mid-chain drops the lock and all pending responses. The ALU carry is cleared via alu_sync_rst after release.
- Op codes pass through unchecked.

Test Plan:
- Reset release: alu_sync_rst=1 for exactly 1 cycle and no req_ready in that cycle; then both requesters valid with op=0, a=3, b=4 -> req0 granted first, rsp_data0=7 next cycle; req1 granted the following cycle.
- Round robin: both valid continuously with ready responses -> grants alternate 0,1,0,1; alu_clk_en high every cycle.
- 16-bit chain on req1: 0x01FF+0x0001 as op=0 (a=FF,b=01,lock=1), then op=1 (a=01,b=00,lock=0), with req0 valid throughout -> results 0x00 then 0x02; req0 stalls until the chain ends, then is granted.
- Lock timeout (LOCK_TIMEOUT=16): req0 issues with lock=1 and then drops valid; req1 valid -> req1 granted exactly 16 cycles after the lock edge; locked=0.
- Backpressure: rsp_ready0=0 with rsp_valid0=1 -> req_ready0=0 and req1 proceeds; raise rsp_ready0 with req0 valid -> consume and refill on the same edge, rsp_valid0 stays 1 with the new data.
- Async reset asserted mid-chain -> locked=0, rsp_valid=0 immediately; after release, op=1 with a=1, b=1 gives 2, confirming the carry buffer was cleared.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NREQ requesters, with chain locking.
// Results are registered per requester one cycle after transfer; requesters stall on a full response register or a foreign lock.
module alu_arbiter #(
  parameter int NREQ         = 2,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [8*NREQ-1:0] rsp_data,
  output logic [NREQ-1:0]   rsp_cond,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_clk_en,
  output logic              alu_sync_rst,
  input  logic [7:0]        alu_out,
  input  logic              alu_cond,
  output logic [1:0]        lock_owner,
  output logic              locked
);

  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t     state;
  logic            init;
  logic [1:0]      rr_ptr;
  logic [CW-1:0]   tmo_cnt;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] owner_sel;
  logic [1:0]      grant_idx;
  logic            found;
  logic            any_grant;
  logic            lock_req;
  logic            owner_xfer;

  // A requester may issue only if its response slot is free or being drained this cycle.
  always_comb begin
    eligible = req_valid & (~rsp_valid | rsp_ready);
  end

  always_comb begin
    owner_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (lock_owner == 2'(i)) owner_sel[i] = 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!init) begin
      if (locked) begin
        grant = eligible & owner_sel;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          for (int j = 0; j < NREQ; j++) begin
            if (!found && (j == (int'(rr_ptr) + k) % NREQ) && eligible[j]) begin
              grant[j] = 1'b1;
              found    = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  always_comb begin
    any_grant  = |grant;
    lock_req   = |(grant & req_lock);
    owner_xfer = |(grant & owner_sel);
  end

  assign req_ready    = grant;
  assign alu_clk_en   = any_grant;
  assign alu_sync_rst = init;

  // Idle cycles drive zeros so the ALU sees a quiet bus and its carry is untouched.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a  = req_a[8*i +: 8];
        alu_b  = req_b[8*i +: 8];
        alu_op = req_op[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_cond  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          rsp_data[8*i +: 8] <= alu_out;
          rsp_cond[i]        <= alu_cond;
          rsp_valid[i]       <= 1'b1;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      init   <= 1'b1;
      rr_ptr <= 2'(NREQ - 1);
    end else begin
      init <= 1'b0;
      if (any_grant) rr_ptr <= grant_idx;
    end
  end

  // Lock FSM: an idle owner (including one blocked by its own full response slot) ages toward timeout.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state      <= UNLOCKED;
      locked     <= 1'b0;
      lock_owner <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (any_grant && lock_req) begin
            state      <= LOCKED;
            locked     <= 1'b1;
            lock_owner <= grant_idx;
            tmo_cnt    <= '0;
          end
        end
        LOCKED: begin
          if (owner_xfer) begin
            tmo_cnt <= '0;
            if (!lock_req) begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          end else if (tmo_cnt == CW'(LOCK_TIMEOUT - 1)) begin
            state   <= UNLOCKED;
            locked  <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
